// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin sharing of one memory-controller command port among NUM_REQ requesters,
// one outstanding command at a time, with read-data/timeout and write-gap completion tracking.
module mem_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WR_GAP     = 4,
  parameter int RD_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_rdnwr,
  input  logic [NUM_REQ*16-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_vld,
  output logic [NUM_REQ-1:0]    rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic                  cmd_n,
  output logic                  RDnWR,
  output logic [15:0]           Addr_in,
  output logic                  Data_in_vld,
  output logic [31:0]           Data_in,
  input  logic [31:0]           Data_out,
  input  logic                  data_out_vld,
  output logic                  busy
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(RD_TIMEOUT > WR_GAP ? RD_TIMEOUT : WR_GAP) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR} state_t;
  state_t r_state, w_next;
  logic [GW-1:0] r_rr, r_g, w_g, w_g_n, w_rr_n;
  logic [GW:0] w_s;
  logic w_any;
  logic [CW-1:0] r_cnt, w_cnt;
  logic w_cmd_n, w_rdnwr, w_dvld, w_busy;
  logic [15:0] w_addr;
  logic [31:0] w_data, w_rdata;
  logic [NUM_REQ-1:0] w_ready, w_rsp, w_err;
  // first requester at or after r_rr, wrapping
  always_comb begin
    w_any = 1'b0;
    w_g = '0;
    w_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_s = {1'b0, r_rr} + (GW+1)'(k);
      if (w_s >= (GW+1)'(NUM_REQ)) w_s = w_s - (GW+1)'(NUM_REQ);
      if (!w_any && req_valid[w_s[GW-1:0]]) begin
        w_any = 1'b1;
        w_g = w_s[GW-1:0];
      end
    end
  end
  // the response cycle is spent in IDLE without arbitrating
  always_comb begin
    w_next = r_state;
    w_g_n = r_g;
    w_rr_n = r_rr;
    w_cnt = r_cnt;
    w_cmd_n = 1'b1;
    w_rdnwr = RDnWR;
    w_addr = Addr_in;
    w_dvld = 1'b0;
    w_data = Data_in;
    w_ready = '0;
    w_rsp = '0;
    w_err = '0;
    w_rdata = '0;
    case (r_state)
      IDLE: if (w_any && ~|rsp_vld) begin
        w_next = ISSUE;
        w_g_n = w_g;
        w_cmd_n = 1'b0;
        w_rdnwr = req_rdnwr[w_g];
        w_addr = req_addr[{w_g, 4'b0} +: 16];
        w_dvld = !req_rdnwr[w_g];
        w_data = req_rdnwr[w_g] ? Data_in : req_wdata[{w_g, 5'b0} +: 32];
        w_ready[w_g] = 1'b1;
      end
      ISSUE: begin
        w_next = RDnWR ? WAIT_RD : WAIT_WR;
        w_rr_n = (r_g == GW'(NUM_REQ-1)) ? '0 : r_g + GW'(1);
        w_cnt = CW'(1);
      end
      WAIT_RD: if (data_out_vld) begin
        w_next = IDLE;
        w_rsp[r_g] = 1'b1;
        w_rdata = Data_out;
      end else if (r_cnt == CW'(RD_TIMEOUT)) begin
        w_next = IDLE;
        w_rsp[r_g] = 1'b1;
        w_err[r_g] = 1'b1;
      end else w_cnt = r_cnt + CW'(1);
      WAIT_WR: if (r_cnt == CW'(WR_GAP)) begin
        w_next = IDLE;
        w_rsp[r_g] = 1'b1;
      end else w_cnt = r_cnt + CW'(1);
      default: w_next = IDLE;
    endcase
    w_busy = w_next != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr <= '0;
      r_g <= '0;
      r_cnt <= '0;
      cmd_n <= 1'b1;
      RDnWR <= 1'b0;
      Addr_in <= '0;
      Data_in_vld <= 1'b0;
      Data_in <= '0;
      req_ready <= '0;
      rsp_vld <= '0;
      rsp_err <= '0;
      rsp_rdata <= '0;
      busy <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rr <= w_rr_n;
      r_g <= w_g_n;
      r_cnt <= w_cnt;
      cmd_n <= w_cmd_n;
      RDnWR <= w_rdnwr;
      Addr_in <= w_addr;
      Data_in_vld <= w_dvld;
      Data_in <= w_data;
      req_ready <= w_ready;
      rsp_vld <= w_rsp;
      rsp_err <= w_err;
      rsp_rdata <= w_rdata;
      busy <= w_busy;
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed and randomized transactions checked against a transaction-level
// model of round-robin arbitration and per-command completion timing.
module tb_mem_req_arbiter;
  localparam int NR = 4;
  localparam int WG = 4;
  localparam int RT = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0] req_valid = '0, req_rdnwr = '0;
  logic [NR*16-1:0] req_addr = '0;
  logic [NR*32-1:0] req_wdata = '0;
  logic [NR-1:0] req_ready, rsp_vld, rsp_err;
  logic [31:0] rsp_rdata, Data_in;
  logic [31:0] Data_out = '0;
  logic data_out_vld = 1'b0;
  logic cmd_n, RDnWR, Data_in_vld, busy;
  logic [15:0] Addr_in;
  int n_pass = 0, n_total = 0;
  logic [NR-1:0] m_valid = '0, m_rd = '0;
  logic [15:0] m_addr [NR];
  logic [31:0] m_wdata [NR];
  logic [31:0] m_din = '0;
  int m_rr = 0;
  bit rsp_last = 0;

  mem_req_arbiter #(.NUM_REQ(NR), .WR_GAP(WG), .RD_TIMEOUT(RT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rdnwr(req_rdnwr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_vld(rsp_vld), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .cmd_n(cmd_n), .RDnWR(RDnWR), .Addr_in(Addr_in),
    .Data_in_vld(Data_in_vld), .Data_in(Data_in), .Data_out(Data_out),
    .data_out_vld(data_out_vld), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  task automatic apply();
    req_valid = m_valid;
    req_rdnwr = m_rd;
    for (int j = 0; j < NR; j++) begin
      req_addr[16*j +: 16] = m_addr[j];
      req_wdata[32*j +: 32] = m_wdata[j];
    end
  endtask

  task automatic add_req(input int j, input bit rd, input logic [15:0] a, input logic [31:0] d);
    m_valid[j] = 1'b1;
    m_rd[j] = rd;
    m_addr[j] = a;
    m_wdata[j] = d;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_n"}, cmd_n, 1);
    chk({tag, "_rdnwr"}, RDnWR, 0);
    chk({tag, "_addr"}, Addr_in, 0);
    chk({tag, "_din_vld"}, Data_in_vld, 0);
    chk({tag, "_din"}, Data_in, 0);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_rsp"}, rsp_vld, 0);
    chk({tag, "_err"}, rsp_err, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    data_out_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    m_rr = 0;
    m_din = '0;
    rsp_last = 0;
  endtask

  task automatic idle(input int n, input bit stray);
    for (int k = 0; k < n; k++) begin
      data_out_vld = stray && k == 0;
      Data_out = $urandom;
      @(negedge clk);
      chk("idle_rsp", rsp_vld, 0);
      chk("idle_busy", busy, 0);
      chk("idle_cmd_n", cmd_n, 1);
    end
    data_out_vld = 1'b0;
    rsp_last = 0;
  endtask

  // one command: lat = cycles after ISSUE at which read data returns (0 or >RT means never)
  task automatic serve(input int lat, input bit hold, input bit stray, input logic [31:0] rdv);
    int g, n, rk, j;
    bit rd, err;
    g = -1;
    for (int k = 0; k < NR; k++) begin
      j = (m_rr + k) % NR;
      if (g < 0 && m_valid[j]) g = j;
    end
    if (g < 0) g = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 8);
    chk("issue_lat", n, rsp_last ? 2 : 1);
    chk("req_ready", req_ready, 1 << g);
    chk("issue_cmd_n", cmd_n, 0);
    rd = m_rd[g];
    chk("issue_rdnwr", RDnWR, rd);
    chk("issue_addr", Addr_in, m_addr[g]);
    chk("issue_din_vld", Data_in_vld, !rd);
    if (!rd) m_din = m_wdata[g];
    chk("issue_din", Data_in, m_din);
    chk("issue_busy", busy, 1);
    m_rr = (g + 1) % NR;
    if (!hold) m_valid[g] = 1'b0;
    apply();
    err = rd && !(lat >= 1 && lat <= RT);
    rk = !rd ? WG + 1 : err ? RT + 1 : lat + 1;
    data_out_vld = 1'b0;
    for (int k = 1; k <= rk; k++) begin
      @(negedge clk);
      if (k < rk) begin
        chk("wait_rsp", rsp_vld, 0);
        chk("wait_busy", busy, 1);
        if (k == 1) begin
          chk("post_issue_cmd_n", cmd_n, 1);
          chk("post_issue_din_vld", Data_in_vld, 0);
          chk("post_issue_ready", req_ready, 0);
          chk("post_issue_addr", Addr_in, m_addr[g]);
        end
      end else begin
        chk("rsp_vld", rsp_vld, 1 << g);
        chk("rsp_err", rsp_err, err ? (1 << g) : 0);
        chk("rsp_rdata", rsp_rdata, (rd && !err) ? rdv : 32'h0);
        chk("rsp_busy", busy, 0);
      end
      data_out_vld = (k < rk) && ((rd && k == lat) || (!rd && stray && k == 2));
      Data_out = data_out_vld ? rdv : $urandom;
    end
    data_out_vld = 1'b0;
    rsp_last = 1;
  endtask

  initial begin
    int n, lat, j;
    for (int i = 0; i < NR; i++) begin
      m_addr[i] = '0;
      m_wdata[i] = '0;
    end
    do_rst();
    add_req(1, 0, 16'h1234, 32'hDEADBEEF);
    apply();
    serve(0, 0, 0, 32'h0);
    add_req(0, 1, 16'h00A5, 32'h0);
    apply();
    serve(3, 0, 0, 32'hCAFEF00D);
    idle(3, 1);
    add_req(3, 0, 16'hBEEF, 32'h01234567);
    apply();
    serve(0, 0, 1, 32'h0);
    add_req(2, 1, 16'h0F0F, 32'h0);
    apply();
    serve(0, 0, 0, 32'h0);
    add_req(1, 1, 16'h7777, 32'h0);
    apply();
    serve(RT, 0, 0, 32'h13572468);
    do_rst();
    for (int i = 0; i < NR; i++) add_req(i, 0, 16'(16'h100 + i), 32'hA0000000 + i);
    apply();
    for (int i = 0; i < NR + 1; i++) serve(0, 1, 0, 32'h0);
    m_valid = '0;
    apply();
    idle(1, 0);
    add_req(2, 1, 16'h2222, 32'h0);
    apply();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 8);
    chk("midrd_ready", req_ready, 4'b0100);
    m_valid = '0;
    apply();
    @(negedge clk);
    @(negedge clk);
    chk("midrd_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("midrd_rst");
    rst = 1'b0;
    m_rr = 0;
    m_din = '0;
    rsp_last = 0;
    @(negedge clk);
    @(negedge clk);
    data_out_vld = 1'b1;
    Data_out = 32'hBADBAD00;
    @(negedge clk);
    data_out_vld = 1'b0;
    chk_reset("midrd_after");
    @(negedge clk);
    chk_reset("midrd_after2");
    add_req(0, 0, 16'h0A0A, 32'h55AA55AA);
    add_req(3, 1, 16'h3B3B, 32'h0);
    apply();
    serve(0, 0, 0, 32'h0);
    serve(2, 0, 0, 32'h89ABCDEF);
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NR; i++)
        if (!m_valid[i] && $urandom_range(0, 1) == 1)
          add_req(i, 1'($urandom_range(0, 1)), 16'($urandom), $urandom);
      if (m_valid == '0) begin
        j = $urandom_range(0, NR - 1);
        add_req(j, 1'($urandom_range(0, 1)), 16'($urandom), $urandom);
      end
      apply();
      lat = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 8);
      serve(lat, 0, 1'($urandom_range(0, 1)), $urandom);
      if (m_valid == '0 && $urandom_range(0, 1) == 1) idle(1, 1'($urandom_range(0, 1)));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
